// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with saturating membrane, shift leak,
// optional 2-bit LFSR noise and a programmable refractory period.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   en             cycle enable; 0 freezes membrane, state and counter
//   in_spike       N_IN spike inputs, bit i active-high
//   weight         packed signed weights, input i at [i*WW +: WW]
//   threshold      unsigned fire threshold; 0 disables firing
//   leak_en        subtract membrane >> LEAK_SHIFT each integrate cycle
//   noise_en       add lfsr[1:0] each integrate cycle
//   spike_out      registered one-cycle spike
//   membrane       current membrane value
//   refrac_active  high while the neuron is refractory
module lif_neuron #(
    parameter int          N_IN       = 4,
    parameter int          W          = 8,
    parameter int          WW         = 4,
    parameter int          LEAK_SHIFT = 3,
    parameter int          REFRAC     = 3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_IN-1:0]      in_spike,
    input  logic [N_IN*WW-1:0]   weight,
    input  logic [W-1:0]         threshold,
    input  logic                 leak_en,
    input  logic                 noise_en,
    output logic                 spike_out,
    output logic [W-1:0]         membrane,
    output logic                 refrac_active
);

    // Internal signed width: membrane plus up to 8 weights plus noise
    // cannot overflow, and a sign bit remains for the low clamp.
    localparam int VW = W + WW + 5;

    localparam logic [3:0] REFRAC_LD = 4'(REFRAC);

    typedef enum logic {
        ST_INTEGRATE,
        ST_REFRACTORY
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    membrane_q, membrane_d;
    logic            spike_q, spike_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;

    logic signed [VW-1:0] sum;
    logic signed [VW-1:0] leak;
    logic signed [VW-1:0] noise;
    logic signed [VW-1:0] v;
    logic [W-1:0]         v_sat;
    logic                 fire;

    // Fibonacci LFSR, taps 16,14,13,11; free-running, ignores en.
    always_comb begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_spike[i]) begin
                sum = sum + {{(VW-WW){weight[i*WW+WW-1]}},
                             weight[i*WW +: WW]};
            end
        end
    end

    always_comb begin
        leak  = '0;
        noise = '0;
        if (leak_en) begin
            leak = {{(VW-W){1'b0}}, membrane_q >> LEAK_SHIFT};
        end
        if (noise_en) begin
            noise = {{(VW-2){1'b0}}, lfsr_q[1:0]};
        end
        v = {{(VW-W){1'b0}}, membrane_q} - leak + sum + noise;
    end

    // Clamp to [0, 2^W-1]: sign bit means negative, any set bit
    // between the sign and the membrane width means above range.
    always_comb begin
        v_sat = v[W-1:0];
        if (v[VW-1]) begin
            v_sat = '0;
        end else if (|v[VW-2:W]) begin
            v_sat = '1;
        end
        fire = (threshold != '0) && (v_sat >= threshold);
    end

    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        cnt_d      = cnt_q;
        spike_d    = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_INTEGRATE: begin
                    if (fire) begin
                        spike_d    = 1'b1;
                        membrane_d = '0;
                        if (REFRAC > 0) begin
                            state_d = ST_REFRACTORY;
                            cnt_d   = REFRAC_LD;
                        end
                    end else begin
                        membrane_d = v_sat;
                    end
                end
                ST_REFRACTORY: begin
                    membrane_d = '0;
                    cnt_d      = cnt_q - 4'd1;
                    // Leaving on the 1->0 step gives exactly REFRAC
                    // enabled cycles of refrac_active.
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = '0;
                        state_d = ST_INTEGRATE;
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INTEGRATE;
            membrane_q <= '0;
            spike_q    <= 1'b0;
            cnt_q      <= '0;
            lfsr_q     <= SEED;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            spike_q    <= spike_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign spike_out     = spike_q;
    assign membrane      = membrane_q;
    assign refrac_active = (state_q == ST_REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: table vectors, corner sequences and random
// stimulus against a behavioural model, for REFRAC=3 and REFRAC=0.
module tb_lif_neuron;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n, en, leak_en, noise_en;
    logic [3:0]  in_spike;
    logic [15:0] weight;
    logic [7:0]  threshold;
    logic        spk_a, ref_a, spk_b, ref_b;
    logic [7:0]  mem_a, mem_b;

    always #5 clk = ~clk;

    lif_neuron #(.REFRAC(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_spike(in_spike),
        .weight(weight), .threshold(threshold), .leak_en(leak_en),
        .noise_en(noise_en), .spike_out(spk_a), .membrane(mem_a),
        .refrac_active(ref_a)
    );

    lif_neuron #(.REFRAC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_spike(in_spike),
        .weight(weight), .threshold(threshold), .leak_en(leak_en),
        .noise_en(noise_en), .spike_out(spk_b), .membrane(mem_b),
        .refrac_active(ref_b)
    );

    int checks = 0;
    int errors = 0;

    // Model: per neuron k (0: REFRAC=3, 1: REFRAC=0), membrane value,
    // remaining refractory cycles, last spike; shared LFSR.
    int          m_mem[2];
    int          m_rem[2];
    int          m_spk[2];
    logic [15:0] m_lfsr;

    task automatic model_step();
        int s, w, lk, nz, v;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_mem[k] = 0;
                m_rem[k] = 0;
                m_spk[k] = 0;
            end
            m_lfsr = SEED;
        end else begin
            s = 0;
            for (int i = 0; i < 4; i++) begin
                if (in_spike[i]) begin
                    w = int'(weight[i*4 +: 4]);
                    if (w > 7) w = w - 16;
                    s = s + w;
                end
            end
            nz = noise_en ? int'(m_lfsr[1:0]) : 0;
            for (int k = 0; k < 2; k++) begin
                m_spk[k] = 0;
                if (en) begin
                    if (m_rem[k] > 0) begin
                        m_rem[k] = m_rem[k] - 1;
                        m_mem[k] = 0;
                    end else begin
                        lk = leak_en ? m_mem[k] / 8 : 0;
                        v = m_mem[k] - lk + s + nz;
                        if (v < 0) v = 0;
                        if (v > 255) v = 255;
                        if (threshold != 0 && v >= int'(threshold)) begin
                            m_spk[k] = 1;
                            m_mem[k] = 0;
                            m_rem[k] = (k == 0) ? 3 : 0;
                        end else begin
                            m_mem[k] = v;
                        end
                    end
                end
            end
            m_lfsr = {m_lfsr[14:0],
                      m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, " mem_a"}, 32'(mem_a), m_mem[0]);
        chk({tag, " spk_a"}, 32'(spk_a), m_spk[0]);
        chk({tag, " ref_a"}, 32'(ref_a), 32'(m_rem[0] > 0));
        chk({tag, " mem_b"}, 32'(mem_b), m_mem[1]);
        chk({tag, " spk_b"}, 32'(spk_b), m_spk[1]);
        chk({tag, " ref_b"}, 32'(ref_b), 32'(m_rem[1] > 0));
    endtask

    task automatic drive(logic r, logic e, logic [3:0] s,
                         logic [15:0] wt, logic [7:0] th,
                         logic l, logic n);
        rst_n     = r;
        en        = e;
        in_spike  = s;
        weight    = wt;
        threshold = th;
        leak_en   = l;
        noise_en  = n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 4'h0, 16'h0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " mem_a"}, 32'(mem_a), 0);
        chk({tag, " spk_a"}, 32'(spk_a), 0);
        chk({tag, " ref_a"}, 32'(ref_a), 0);
        chk({tag, " mem_b"}, 32'(mem_b), 0);
        chk({tag, " spk_b"}, 32'(spk_b), 0);
        chk({tag, " ref_b"}, 32'(ref_b), 0);
    endtask

    typedef struct {
        logic        r;
        logic        e;
        logic [3:0]  s;
        logic [15:0] wt;
        logic [7:0]  th;
        logic        l;
        logic        n;
        logic [7:0]  ma;
        logic        sa;
        logic        ra;
        logic [7:0]  mb;
        logic        sb;
        logic        rb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int active;
        string t;

        // Single input +7, threshold 20, leak on.
        tbl[0] = '{1'b0, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd7, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd14, 1'b0, 1'b0, 8'd14, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd0, 1'b0, 1'b1, 8'd14, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0,
                   8'd7, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].wt, tbl[i].th,
                  tbl[i].l, tbl[i].n);
            tick();
            t = $sformatf("tbl%0d", i);
            chk({t, " mem_a"}, 32'(mem_a), 32'(tbl[i].ma));
            chk({t, " spk_a"}, 32'(spk_a), 32'(tbl[i].sa));
            chk({t, " ref_a"}, 32'(ref_a), 32'(tbl[i].ra));
            chk({t, " mem_b"}, 32'(mem_b), 32'(tbl[i].mb));
            chk({t, " spk_b"}, 32'(spk_b), 32'(tbl[i].sb));
            chk({t, " ref_b"}, 32'(ref_b), 32'(tbl[i].rb));
            chk_model(t);
        end

        // Saturation high.
        do_reset();
        drive(1'b1, 1'b1, 4'hF, 16'h7777, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            t = $sformatf("sat_hi%0d", k);
            chk({t, " mem_a"}, 32'(mem_a), (28 * k > 255) ? 255 : 28 * k);
            chk({t, " spk_a"}, 32'(spk_a), 0);
            chk({t, " mem_b"}, 32'(mem_b), (28 * k > 255) ? 255 : 28 * k);
        end

        // Saturation low.
        do_reset();
        drive(1'b1, 1'b1, 4'h1, 16'h0005, 8'd0, 1'b0, 1'b0);
        tick();
        chk("sat_lo start", 32'(mem_a), 5);
        drive(1'b1, 1'b1, 4'h1, 16'h0008, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            t = $sformatf("sat_lo%0d", k);
            chk({t, " mem_a"}, 32'(mem_a), 0);
            chk({t, " mem_b"}, 32'(mem_b), 0);
        end

        // Noise determinism.
        do_reset();
        drive(1'b1, 1'b1, 4'h0, 16'h0, 8'd0, 1'b0, 1'b1);
        tick();
        chk("noise first", 32'(mem_a), 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_model($sformatf("noise%0d", k));
        end

        // en gating during refractory.
        do_reset();
        drive(1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("gate fire spk_a", 32'(spk_a), 1);
        chk("gate fire ref_a", 32'(ref_a), 1);
        active = 1;
        for (int k = 0; k < 7; k++) begin
            en = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            tick();
            t = $sformatf("gate%0d", k);
            if (!en) begin
                chk({t, " hold ref_a"}, 32'(ref_a), 1);
                chk({t, " hold mem_a"}, 32'(mem_a), 0);
            end else if (ref_a) begin
                active++;
            end
            chk_model(t);
        end
        chk("gate active cycles", 32'(active), 3);
        chk("gate resume mem_a", 32'(mem_a), 14);

        // Reset during refractory.
        do_reset();
        drive(1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("rst_ref pre ref_a", 32'(ref_a), 1);
        rst_n = 1'b0;
        tick();
        chk_zero("rst_ref");
        drive(1'b1, 1'b1, 4'h0, 16'h0, 8'd0, 1'b0, 1'b1);
        tick();
        chk("rst_ref seed", 32'(mem_a), 1);

        // Reset during integration.
        do_reset();
        drive(1'b1, 1'b1, 4'h1, 16'h0007, 8'd20, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_int pre mem_a", 32'(mem_a), 14);
        rst_n = 1'b0;
        tick();
        chk_zero("rst_int");
        drive(1'b1, 1'b1, 4'h0, 16'h0, 8'd0, 1'b0, 1'b1);
        tick();
        chk("rst_int seed", 32'(mem_a), 1);

        // Randomised run against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) < 8),
                  4'($urandom),
                  16'($urandom),
                  8'($urandom_range(0, 60)),
                  1'($urandom),
                  1'($urandom));
            tick();
            chk_model($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
